// File: rtl/qam_pkg.sv
// Shared constants, output FSM state type and parameter checks for the QAM symbol mapper.
package qam_pkg;

  localparam int L_M3 = -3;
  localparam int L_M1 = -1;
  localparam int L_P1 = 1;
  localparam int L_P3 = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  function automatic bit bits_per_sym_ok(input int bps);
    return (bps == 2) || (bps == 4);
  endfunction

endpackage

// File: rtl/qam_symbol_mapper_if.sv
// Bit-stream input, symbol handshake and status signals of the QAM symbol mapper.
interface qam_symbol_mapper_if #(
  parameter int BITS_PER_SYM = 4,
  parameter int LVL_W        = 3
);
  logic                    bit_in;
  logic                    bit_strobe;
  logic                    align;
  logic                    sym_ready;
  logic                    sym_valid;
  logic [BITS_PER_SYM-1:0] sym_bits;
  logic signed [LVL_W-1:0] i_level;
  logic signed [LVL_W-1:0] q_level;
  logic                    overflow;
  logic [1:0]              bit_cnt;

  modport master (
    output bit_in, bit_strobe, align, sym_ready,
    input  sym_valid, sym_bits, i_level, q_level, overflow, bit_cnt
  );

  modport slave (
    input  bit_in, bit_strobe, align, sym_ready,
    output sym_valid, sym_bits, i_level, q_level, overflow, bit_cnt
  );
endinterface

// File: rtl/qam_gray_lut.sv
// Combinational Gray-pair (or single-bit) to signed amplitude level lookup.
module qam_gray_lut
  import qam_pkg::*;
#(
  parameter int CODE_W = 2,
  parameter int LVL_W  = 3
) (
  input  logic [CODE_W-1:0]       code_i,
  output logic signed [LVL_W-1:0] level_o
);

  if (CODE_W == 1) begin : g_qpsk
    assign level_o = code_i[0] ? LVL_W'(L_P1) : LVL_W'(L_M1);
  end else begin : g_gray
    // Adjacent levels differ in exactly one bit
    always_comb begin
      level_o = LVL_W'(L_M3);
      unique case (code_i[1:0])
        2'b00: level_o = LVL_W'(L_M3);
        2'b01: level_o = LVL_W'(L_M1);
        2'b11: level_o = LVL_W'(L_P1);
        2'b10: level_o = LVL_W'(L_P3);
        default: level_o = LVL_W'(L_M3);
      endcase
    end
  end

endmodule

// File: rtl/qam_symbol_mapper.sv
// Serial-to-symbol assembler with Gray I/Q mapping and a single-entry valid/ready output register.
module qam_symbol_mapper
  import qam_pkg::*;
#(
  parameter int BITS_PER_SYM = 4,
  parameter int LVL_W        = 3
) (
  input  logic              clock,
  input  logic              reset,
  qam_symbol_mapper_if.slave bus
);

  if (!bits_per_sym_ok(BITS_PER_SYM)) begin : g_bad_bps
    $error("qam_symbol_mapper: BITS_PER_SYM must be 2 or 4");
  end
  if (LVL_W < 3) begin : g_bad_lvl
    $error("qam_symbol_mapper: LVL_W must be at least 3");
  end

  localparam logic [1:0] LAST_CNT = 2'(BITS_PER_SYM - 1);

  logic [BITS_PER_SYM-2:0] sr_q, sr_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [BITS_PER_SYM-1:0] word;
  logic                    complete;

  out_state_e              state_q, state_d;
  logic                    load;
  logic                    ovf_q, ovf_d;
  logic [BITS_PER_SYM-1:0] bits_q;
  logic signed [LVL_W-1:0] i_q, q_q;
  logic signed [LVL_W-1:0] i_map, q_map;

  assign word     = {sr_q, bus.bit_in};
  // A strobe coinciding with align starts a new word, so it never completes one
  assign complete = bus.bit_strobe && !bus.align && (cnt_q == LAST_CNT);

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (bus.align) begin
      sr_d  = bus.bit_strobe ? (BITS_PER_SYM-1)'(bus.bit_in) : '0;
      cnt_d = bus.bit_strobe ? 2'd1 : 2'd0;
    end else if (bus.bit_strobe) begin
      sr_d  = word[BITS_PER_SYM-2:0];
      cnt_d = complete ? 2'd0 : cnt_q + 2'd1;
    end
  end

  if (BITS_PER_SYM == 4) begin : g_qam16
    qam_gray_lut #(.CODE_W(2), .LVL_W(LVL_W)) u_lut_i (.code_i(word[3:2]), .level_o(i_map));
    qam_gray_lut #(.CODE_W(2), .LVL_W(LVL_W)) u_lut_q (.code_i(word[1:0]), .level_o(q_map));
  end else begin : g_qpsk
    qam_gray_lut #(.CODE_W(1), .LVL_W(LVL_W)) u_lut_i (.code_i(word[1]), .level_o(i_map));
    qam_gray_lut #(.CODE_W(1), .LVL_W(LVL_W)) u_lut_q (.code_i(word[0]), .level_o(q_map));
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ovf_d   = ovf_q;
    unique case (state_q)
      EMPTY: begin
        if (complete) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (bus.sym_ready) begin
          if (complete) load = 1'b1;
          else          state_d = EMPTY;
        end else if (complete) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sr_q    <= '0;
      cnt_q   <= 2'd0;
      state_q <= EMPTY;
      ovf_q   <= 1'b0;
      bits_q  <= '0;
      i_q     <= '0;
      q_q     <= '0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
      if (load) begin
        bits_q <= word;
        i_q    <= i_map;
        q_q    <= q_map;
      end
    end
  end

  assign bus.sym_valid = (state_q == FULL);
  assign bus.sym_bits  = bits_q;
  assign bus.i_level   = i_q;
  assign bus.q_level   = q_q;
  assign bus.overflow  = ovf_q;
  assign bus.bit_cnt   = cnt_q;

endmodule
